// File: rtl/rf_sched_pkg.sv
// ---------------------------------------------------------------------------
// rf_sched_pkg
//   Shared types and helpers for the register-file write scheduler.
//   - state_t        : scheduler state (S_INIT sweep / S_RUN arbitration)
//   - ptr_width()    : width of the round-robin pointer for a given n_req
//   - addr_in_range(): inclusive lo..hi address check
// ---------------------------------------------------------------------------
package rf_sched_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic logic addr_in_range(input int unsigned addr,
                                         input int unsigned lo,
                                         input int unsigned hi);
    return (addr >= lo) && (addr <= hi);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
//   Purely combinational round-robin grant. Searches req from ptr upward,
//   modulo n_req, and grants the first requester found. The pointer register
//   lives in the parent.
//   Ports:
//     req       in  n_req  request vector
//     ptr       in  ptr_w  index where the search starts (must be < n_req)
//     grant     out n_req  one-hot grant, zero when no request
//     grant_idx out ptr_w  index of the granted requester
//     any_grant out 1      a grant was issued
// ---------------------------------------------------------------------------
module rr_arbiter
  import rf_sched_pkg::*;
#(
  parameter int n_req = 3,
  parameter int ptr_w = ptr_width(n_req)
) (
  input  logic [n_req-1:0] req,
  input  logic [ptr_w-1:0] ptr,
  output logic [n_req-1:0] grant,
  output logic [ptr_w-1:0] grant_idx,
  output logic             any_grant
);

  // NOTE: every output of this always_comb gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    int idx;
    grant     = '0;
    grant_idx = '0;
    any_grant = 1'b0;
    // Walk offsets from the far end back towards ptr; the last hit written
    // is the one closest to ptr, which is the round-robin winner.
    for (int k = n_req - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % n_req;
      if (req[idx]) begin
        grant_idx = ptr_w'(idx);
        any_grant = 1'b1;
      end
    end
    if (any_grant) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_sched.sv
// ---------------------------------------------------------------------------
// regfile_write_sched
//   Shares the single register-file write port between n_req requesters with
//   a round-robin valid/ready handshake, and runs an initialisation sweep
//   (init_value to every address lo..hi) after reset or on INIT_START.
//   All register-file controls (RF_WE/RF_ADDR_IN/RF_D_IN) are registered.
//   Ports:
//     CLK, RST    clock; asynchronous active-high reset
//     REQ_VALID   in  n_req             per-requester write request
//     REQ_READY   out n_req             one-hot grant (zero in S_INIT)
//     REQ_ADDR    in  n_req*addr_width  packed, requester i at [i*aw +: aw]
//     REQ_DATA    in  n_req*data_width  packed, same layout
//     INIT_START  in  1                 request a re-initialisation sweep
//     RF_ADDR_IN  out addr_width        register-file write address
//     RF_D_IN     out data_width        register-file write data
//     RF_WE       out 1                 register-file write enable
//     INIT_DONE   out 1                 high while arbitrating (S_RUN)
//     ERR_OOR     out 1                 pulse: accepted address out of range
// ---------------------------------------------------------------------------
module regfile_write_sched
  import rf_sched_pkg::*;
#(
  parameter int n_req      = 3,
  parameter int addr_width = 5,
  parameter int data_width = 32,
  parameter int lo         = 0,
  parameter int hi         = 31,
  parameter logic [data_width-1:0] init_value = '0
) (
  input  logic                        CLK,
  input  logic                        RST,
  input  logic [n_req-1:0]            REQ_VALID,
  output logic [n_req-1:0]            REQ_READY,
  input  logic [n_req*addr_width-1:0] REQ_ADDR,
  input  logic [n_req*data_width-1:0] REQ_DATA,
  input  logic                        INIT_START,
  output logic [addr_width-1:0]       RF_ADDR_IN,
  output logic [data_width-1:0]       RF_D_IN,
  output logic                        RF_WE,
  output logic                        INIT_DONE,
  output logic                        ERR_OOR
);

  localparam int PTR_W = ptr_width(n_req);
  localparam logic [addr_width-1:0] LO_A = addr_width'(lo);
  localparam logic [addr_width-1:0] HI_A = addr_width'(hi);

  state_t                  state;
  logic [addr_width-1:0]   cnt;
  logic [PTR_W-1:0]        ptr;

  logic [n_req-1:0]        grant;
  logic [PTR_W-1:0]        grant_idx;
  logic [PTR_W-1:0]        ptr_next;
  logic                    any_grant;
  logic                    arb_open;
  logic                    xfer;
  logic                    sel_ok;
  logic [addr_width-1:0]   sel_addr;
  logic [data_width-1:0]   sel_data;

  rr_arbiter #(
    .n_req (n_req),
    .ptr_w (PTR_W)
  ) u_arb (
    .req       (REQ_VALID),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_grant (any_grant)
  );

  // INIT_START wins over requests: nobody is granted in the cycle it is seen.
  assign arb_open  = (state == S_RUN) && !INIT_START;
  assign REQ_READY = arb_open ? grant : '0;
  assign xfer      = arb_open && any_grant;

  assign sel_addr = REQ_ADDR[int'(grant_idx)*addr_width +: addr_width];
  assign sel_data = REQ_DATA[int'(grant_idx)*data_width +: data_width];
  assign sel_ok   = addr_in_range(32'(sel_addr), lo, hi);
  assign ptr_next = (grant_idx == PTR_W'(n_req - 1)) ? '0
                                                      : grant_idx + PTR_W'(1);

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= S_INIT;
      cnt        <= LO_A;
      ptr        <= '0;
      RF_WE      <= 1'b0;
      RF_ADDR_IN <= LO_A;
      RF_D_IN    <= '0;
      INIT_DONE  <= 1'b0;
      ERR_OOR    <= 1'b0;
    end else begin
      ERR_OOR <= 1'b0;
      case (state)
        S_INIT: begin
          RF_WE      <= 1'b1;
          RF_ADDR_IN <= cnt;
          RF_D_IN    <= init_value;
          // Compare before incrementing so hi at the top of the address
          // space never wraps.
          if (cnt == HI_A) begin
            state     <= S_RUN;
            INIT_DONE <= 1'b1;
          end else begin
            cnt <= cnt + addr_width'(1);
          end
        end
        S_RUN: begin
          if (INIT_START) begin
            state     <= S_INIT;
            cnt       <= LO_A;
            INIT_DONE <= 1'b0;
            RF_WE     <= 1'b0;
          end else if (xfer) begin
            // Out-of-range requests are still consumed; the write is
            // suppressed and flagged instead.
            ptr        <= ptr_next;
            RF_ADDR_IN <= sel_addr;
            RF_D_IN    <= sel_data;
            RF_WE      <= sel_ok;
            ERR_OOR    <= !sel_ok;
          end else begin
            RF_WE <= 1'b0;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule
